// File: rtl/gemm_feeder.sv
// Streaming front end for gemm_core: loads m1 then m2 through the core write
// port, pulses start, waits for done and returns sum_out on a valid/ready port.
// Optional watchdog on the wait for done: define GEMM_FEEDER_TIMEOUT_EN.
module gemm_feeder #(
  parameter int N         = 16,
  parameter int DW        = 21,
  parameter int AW        = 8,
  parameter int SW        = 32,
  parameter int START_GAP = 3,
  parameter int TIMEOUT   = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          wr_en,
  output logic [1:0]    wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          start,
  input  logic          done,
  input  logic [SW-1:0] sum_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [SW-1:0] res_data,
  output logic          busy,
  output logic          err
);

  localparam int            NN   = N * N;
  localparam logic [AW-1:0] LAST = AW'(NN - 1);
  localparam int            GW   = $clog2(START_GAP + 1);

  if (START_GAP < 1 || AW != $clog2(N * N) || TIMEOUT < 1) begin : g_param_check
    $error("gemm_feeder: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    LOAD_M1,
    LOAD_M2,
    GAP,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    RESULT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic          run_q;
  logic          accept;
  logic          timeout;

  assign accept = s_valid && s_ready;

`ifdef GEMM_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == WAIT_LOW || state == WAIT_HIGH) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  // A done arriving on the very last allowed cycle still wins over the abort.
  assign timeout = (wd_cnt == TW'(TIMEOUT)) &&
                   (state == WAIT_LOW || (state == WAIT_HIGH && !done));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and the order of statements never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_M1;
      run_q <= 1'b0;
    end else begin
      state <= state_nx;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nx = state;
    case (state)
      LOAD_M1:   if (accept && cnt == LAST) state_nx = LOAD_M2;
      LOAD_M2:   if (accept && cnt == LAST) state_nx = GAP;
      GAP:       if (gap_cnt == GW'(START_GAP)) state_nx = START;
      START:     state_nx = WAIT_LOW;
      WAIT_LOW: begin
        if (timeout)   state_nx = LOAD_M1;
        else if (!done) state_nx = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (timeout)   state_nx = LOAD_M1;
        else if (done) state_nx = RESULT;
      end
      RESULT:    if (res_ready) state_nx = LOAD_M1;
      default:   state_nx = LOAD_M1;
    endcase
  end

  // Handshake outputs decode the state; run_q keeps s_ready low while in reset.
  always_comb begin
    s_ready   = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    err       = timeout;
    busy      = !(state == LOAD_M1 && cnt == '0);
    case (state)
      LOAD_M1, LOAD_M2: s_ready   = run_q;
      START:            start     = 1'b1;
      RESULT:           res_valid = 1'b1;
      default:          ;
    endcase
  end

  // The GAP state also covers the final write cycle, hence START_GAP+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_sel   <= 2'd0;
      wr_addr  <= '0;
      wr_data  <= '0;
      res_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_sel  <= {1'b0, state == LOAD_M2};
        wr_addr <= cnt;
        wr_data <= s_data;
      end
      if (state == WAIT_HIGH && done) res_data <= sum_out;
    end
  end

endmodule

// File: tb/tb_gemm_feeder.sv
// Bench for gemm_feeder: drives element streams, models gemm_core behaviourally
// and checks write traffic, start timing and results against a reference sum.
module tb_gemm_feeder;

  localparam int N = 16, DW = 21, AW = 8, SW = 32, START_GAP = 3, TIMEOUT = 64;
  localparam int NN = N * N;
  localparam int P_ONES = 0, P_IDENT = 1, P_ROW = 2, P_COL = 3, P_RAND = 4;
`ifdef GEMM_FEEDER_TIMEOUT_EN
  localparam int EXP_ERR_PULSES = 1;
`else
  localparam int EXP_ERR_PULSES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start, done;
  logic [SW-1:0] sum_out;
  logic          res_valid, res_ready;
  logic [SW-1:0] res_data;
  logic          busy, err;

  always #5 clk = ~clk;

  gemm_feeder #(.N(N), .DW(DW), .AW(AW), .SW(SW), .START_GAP(START_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .done(done), .sum_out(sum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int      errors = 0, checks = 0;
  longint  cyc = 0;
  int      n_writes = 0, n_starts = 0, n_err = 0;
  wr_t     exp_wr[$];
  logic signed [DW-1:0] stim [2*NN];

  always @(posedge clk) cyc <= cyc + 1;

  // gemm_core model: captures writes, drops done some cycles after start,
  // raises it with the matrix-product element sum after a latency.
  logic signed [DW-1:0] core_mem [2][NN];
  bit core_never = 1'b0;
  int core_drop = 0, core_lat = 12;

  always @(posedge clk) if (wr_en) core_mem[wr_sel[0]][wr_addr] <= wr_data;

  function automatic logic [SW-1:0] core_result();
    longint acc = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          acc += longint'(core_mem[0][i*N+k]) * longint'(core_mem[1][k*N+j]);
    return SW'(acc);
  endfunction

  initial begin
    done = 1'b0;
    sum_out = '0;
    forever begin
      @(posedge clk);
      if (start) begin
        repeat (core_drop) @(posedge clk);
        done <= 1'b0;
        if (!core_never) begin
          repeat (core_lat) @(posedge clk);
          sum_out <= core_result();
          done <= 1'b1;
        end
      end
    end
  end

  // Reference: sum of all entries of A*B equals sum_k colsum_A[k] * rowsum_B[k].
  function automatic logic [SW-1:0] ref_sum();
    longint cs, rs, acc = 0;
    for (int k = 0; k < N; k++) begin
      cs = 0;
      rs = 0;
      for (int i = 0; i < N; i++) begin
        cs += longint'(stim[i*N+k]);
        rs += longint'(stim[NN+k*N+i]);
      end
      acc += cs * rs;
    end
    return SW'(acc);
  endfunction

  function automatic logic signed [DW-1:0] pat(input int p, input int r, input int c);
    logic signed [DW-1:0] v;
    case (p)
      P_ONES:  v = 1;
      P_IDENT: v = (r == c) ? 1 : 0;
      P_ROW:   v = DW'(r + 1);
      P_COL:   v = DW'(c + 1);
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  task automatic fill(input int pa, input int pb);
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          stim[m*NN+r*N+c] = pat((m == 0) ? pa : pb, r, c);
  endtask

  task automatic monitor();
    wr_t    got, want;
    longint last_wr = -100;
    bit     prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        got.sel = wr_sel; got.addr = wr_addr; got.data = wr_data;
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got sel=%0d addr=%0d data=%h, expected no write", wr_sel, wr_addr, wr_data);
        end else begin
          want = exp_wr.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL write_content: got sel=%0d addr=%0d data=%h, expected sel=%0d addr=%0d data=%h",
                     got.sel, got.addr, got.data, want.sel, want.addr, want.data);
          end
        end
        n_writes++;
        last_wr = cyc;
      end
      if (start) begin
        checks++;
        if (cyc - last_wr != START_GAP + 1 || wr_en || prev_start) begin
          errors++;
          $display("FAIL start_timing: start %0d cycles after last write (wr_en=%0b prev_start=%0b), expected %0d",
                   cyc - last_wr, wr_en, prev_start, START_GAP + 1);
        end
        n_starts++;
      end
      if (err) n_err++;
      prev_start = start;
    end
  endtask

  // mode 0: continuous valid, 1: toggled every cycle, 2: random with garbage data when idle
  task automatic send_stream(input int mode, input int count);
    int idx = 0, budget = 0;
    bit tog = 1'b1;
    wr_t w;
    while (idx < count && budget < 20000) begin
      @(negedge clk);
      budget++;
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = tog; tog = !tog; end
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = s_valid ? stim[idx] : DW'($urandom);
      if (s_valid && s_ready) begin
        w.sel = 2'(idx / NN); w.addr = AW'(idx % NN); w.data = stim[idx];
        exp_wr.push_back(w);
        idx++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (idx != count) begin
      errors++;
      $display("FAIL stream_accept: accepted %0d elements, expected %0d", idx, count);
    end
  endtask

  task automatic get_result(input logic [SW-1:0] exp, input int hold, input string name);
    int budget = 0;
    res_ready = 1'b0;
    @(negedge clk);
    while (!res_valid && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_result_wait: res_valid still %b after %0d cycles, expected 1", name, res_valid, budget);
      return;
    end
    checks++;
    if (res_data !== exp || s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_result: res_data=%0d s_ready=%b busy=%b, expected res_data=%0d s_ready=0 busy=1",
               name, res_data, s_ready, busy, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold: cycle %0d res_valid=%b res_data=%0d s_ready=%b, expected 1/%0d/0",
                 name, i, res_valid, res_data, s_ready, exp);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: res_valid=%b s_ready=%b busy=%b, expected 0/1/0", name, res_valid, s_ready, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({s_ready, wr_en, wr_sel, wr_addr, wr_data, start, res_valid, res_data, busy, err} !== '0) begin
      errors++;
      $display("FAIL %s_outputs: s_ready=%b wr_en=%b wr_sel=%0d wr_addr=%0d wr_data=%h start=%b res_valid=%b res_data=%h busy=%b err=%b, expected all 0",
               name, s_ready, wr_en, wr_sel, wr_addr, wr_data, start, res_valid, res_data, busy, err);
    end
  endtask

  task automatic release_reset(input string name);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_early: s_ready=%b right after release, expected 0", name, s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_rise: s_ready=%b busy=%b one clock after release, expected 1/0", name, s_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    release_reset("reset");
  endtask

  task automatic run(input int pa, input int pb, input int mode, input logic [SW-1:0] exp,
                     input int hold, input string name);
    int w0 = n_writes, s0 = n_starts;
    fill(pa, pb);
    send_stream(mode, 2 * NN);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: busy=%b after load, expected 1", name, busy);
    end
    get_result(exp, hold, name);
    checks++;
    if (n_writes - w0 != 2 * NN || n_starts - s0 != 1 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_counts: writes=%0d starts=%0d pending=%0d, expected %0d/1/0",
               name, n_writes - w0, n_starts - s0, exp_wr.size(), 2 * NN);
    end
  endtask

  task automatic test_all_ones();
    core_drop = 0; core_lat = 12;
    run(P_ONES, P_ONES, 0, 32'd4096, 0, "all_ones");
  endtask

  task automatic test_toggle_valid();
    run(P_IDENT, P_COL, 1, 32'd2176, 0, "toggle_valid");
  endtask

  task automatic test_result_hold();
    run(P_ROW, P_COL, 0, 32'd295936, 20, "result_hold");
  endtask

  task automatic test_back_to_back();
    core_drop = 0;
    run(P_ONES, P_ONES, 0, 32'd4096, 0, "b2b_first");
    core_drop = 6;
    run(P_ROW, P_ONES, 0, 32'd34816, 0, "b2b_second");
    core_drop = 0;
  endtask

  task automatic test_reset_mid_load();
    fill(P_RAND, P_RAND);
    send_stream(0, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_pending: %0d writes never appeared, expected 0", exp_wr.size());
    end
    release_reset("mid_reset");
    run(P_IDENT, P_ONES, 0, 32'd256, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      core_drop = $urandom_range(0, 4);
      core_lat  = $urandom_range(1, 20);
      res_ready = 1'b1;
      fill(P_RAND, P_RAND);
      send_stream(2, 2 * NN);
      get_result(ref_sum(), $urandom_range(0, 5), "random");
    end
    core_drop = 0; core_lat = 12;
  endtask

`ifdef GEMM_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int s0 = n_starts, k = 0, budget = 0;
    core_never = 1'b1;
    fill(P_RAND, P_RAND);
    send_stream(0, 2 * NN);
    while (n_starts == s0 && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    checks++;
    if (n_starts == s0) begin
      errors++;
      $display("FAIL timeout_start: no start after load, expected one");
    end
    while (!err && k < 4 * TIMEOUT) begin
      @(negedge clk);
      k++;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_res_valid: res_valid=%b while waiting, expected 0", res_valid);
      end
    end
    checks++;
    if (err !== 1'b1 || k != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_err: err=%b at %0d cycles after start, expected 1 at %0d", err, k, TIMEOUT + 1);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || s_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: err=%b s_ready=%b res_valid=%b busy=%b, expected 0/1/0/0",
               err, s_ready, res_valid, busy);
    end
    core_never = 1'b0;
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_all_ones();
    test_toggle_valid();
    test_result_hold();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
`ifdef GEMM_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge clk);
    checks++;
    if (n_err != EXP_ERR_PULSES) begin
      errors++;
      $display("FAIL err_pulses: saw %0d err cycles, expected %0d", n_err, EXP_ERR_PULSES);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not complete within 60000 cycles");
    $fatal(1, "global timeout");
  end

endmodule
